// File: rtl/gate4_sweep_ctrl.sv
// Exhaustive 4-input gate tester: walks vectors 0..15, holds each for SETTLE_CYCLES,
// then compares the gate output against a latched truth table and reports mismatches.
module gate4_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_truth,
    input  logic        i_f,
    output logic        o_a,
    output logic        o_b,
    output logic        o_c,
    output logic        o_d,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [4:0]  o_err_cnt,
    output logic [3:0]  o_first_err_vec,
    output logic        o_first_err_valid
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] truth_q, truth_d;
    logic [4:0]  err_cnt_q, err_cnt_d;
    logic [3:0]  first_vec_q, first_vec_d;
    logic        first_valid_q, first_valid_d;
    logic        pass_q, pass_d;
    logic        mismatch;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            vec_q         <= 4'd0;
            cnt_q         <= 8'd0;
            truth_q       <= 16'd0;
            err_cnt_q     <= 5'd0;
            first_vec_q   <= 4'd0;
            first_valid_q <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            cnt_q         <= cnt_d;
            truth_q       <= truth_d;
            err_cnt_q     <= err_cnt_d;
            first_vec_q   <= first_vec_d;
            first_valid_q <= first_valid_d;
            pass_q        <= pass_d;
        end
    end

    assign mismatch = (i_f != truth_q[vec_q]);

    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        cnt_d         = cnt_q;
        truth_d       = truth_q;
        err_cnt_d     = err_cnt_q;
        first_vec_d   = first_vec_q;
        first_valid_d = first_valid_q;
        pass_d        = pass_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    truth_d       = i_truth;
                    vec_d         = 4'd0;
                    cnt_d         = 8'd0;
                    err_cnt_d     = 5'd0;
                    first_valid_d = 1'b0;
                    state_d       = SETTLE;
                end
            end
            SETTLE: begin
                if (i_abort) begin
                    state_d = IDLE;
                    vec_d   = 4'd0;
                    cnt_d   = 8'd0;
                    pass_d  = 1'b0;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                // Abort wins: the compare of this cycle is dropped entirely.
                if (i_abort) begin
                    state_d = IDLE;
                    vec_d   = 4'd0;
                    cnt_d   = 8'd0;
                    pass_d  = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_cnt_d = err_cnt_q + 5'd1;
                        if (!first_valid_q) begin
                            first_vec_d   = vec_q;
                            first_valid_d = 1'b1;
                        end
                    end
                    if (vec_q == 4'd15) begin
                        state_d = DONE;
                        pass_d  = (err_cnt_d == 5'd0);
                    end else begin
                        vec_d   = vec_q + 4'd1;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                vec_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_busy            = (state_q == SETTLE) || (state_q == SAMPLE);
    assign o_done            = (state_q == DONE);
    assign o_a               = o_busy & vec_q[3];
    assign o_b               = o_busy & vec_q[2];
    assign o_c               = o_busy & vec_q[1];
    assign o_d               = o_busy & vec_q[0];
    assign o_pass            = pass_q;
    assign o_err_cnt         = err_cnt_q;
    assign o_first_err_vec   = first_vec_q;
    assign o_first_err_valid = first_valid_q;

endmodule

// File: doc/gate4_sweep_ctrl.md
GATE4_SWEEP_CTRL -- requirements
Module: gate4_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, which sets the number of cycles each vector is held before sampling; legal range 1..255.
REQ-002 The block SHALL have port i_clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-005 The block SHALL have port i_abort, input, 1 bit: terminates a running sweep.
REQ-006 The block SHALL have port i_truth, input, 16 bits: expected output table; bit k is the expected o_f for vector k.
REQ-007 The block SHALL have port i_f, input, 1 bit: output of the 4-input gate under test.
REQ-008 The block SHALL have ports o_a, o_b, o_c, o_d, output, 1 bit each: vector drive; o_a = vec[3] (MSB), o_d = vec[0].
REQ-009 The block SHALL have port o_busy, output, 1 bit: sweep in progress.
REQ-010 The block SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port o_pass, output, 1 bit: last completed sweep had zero mismatches.
REQ-012 The block SHALL have port o_err_cnt, output, 5 bits: mismatch count, range 0..16.
REQ-013 The block SHALL have port o_first_err_vec, output, 4 bits: index of the lowest mismatching vector.
REQ-014 The block SHALL have port o_first_err_valid, output, 1 bit: o_first_err_vec is meaningful.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 In IDLE with i_start=1, the block SHALL latch i_truth, clear vec, the settle counter, o_err_cnt and o_first_err_valid, and enter SETTLE; i_truth changes after this point SHALL have no effect until the next start.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles with vec driven constant, then go to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle and compare i_f against latched truth bit vec; on mismatch the block SHALL increment o_err_cnt and, if o_first_err_valid=0, set o_first_err_vec=vec and o_first_err_valid=1.
REQ-019 From SAMPLE with vec<15, the block SHALL increment vec and return to SETTLE; with vec=15 it SHALL go to DONE, and vec SHALL NOT wrap.
REQ-020 DONE SHALL last one cycle with o_done=1, update o_pass=(o_err_cnt==0) including that cycle's final compare, and then return to IDLE.
REQ-021 Latency: o_done SHALL be high in the cycle 16*(SETTLE_CYCLES+1)+1 cycles after the edge that accepted i_start.
REQ-022 o_busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-023 o_a..o_d SHALL be 0 in IDLE and DONE.
REQ-024 i_start SHALL be ignored outside IDLE; a start held high SHALL re-trigger only once IDLE is re-entered.
REQ-025 i_abort=1 in SETTLE or SAMPLE SHALL return the FSM to IDLE at the next edge: no o_done pulse, o_pass forced 0, o_err_cnt and o_first_err_* retain partial values.
REQ-026 i_abort SHALL take priority over a SAMPLE compare in the same cycle; that compare SHALL be discarded.
REQ-027 i_abort in IDLE or DONE SHALL have no effect.
REQ-028 o_err_cnt SHALL saturate naturally at 16, with no wrap, since at most 16 compares occur.
REQ-029 o_pass, o_err_cnt and o_first_err_* SHALL hold their values after DONE until the next accepted start.

Reset
REQ-030 While i_rst_n=0, the block SHALL immediately force state=IDLE, vec=0, o_a..o_d=0, o_busy=0, o_done=0, o_pass=0, o_err_cnt=0, o_first_err_vec=0 and o_first_err_valid=0, independent of i_clk.
REQ-031 Reset asserted mid-sweep SHALL abandon the sweep without an o_done pulse, and after release the block SHALL wait in IDLE for a new i_start.

Verification
REQ-032 Correct NAND4 gate, i_truth=16'h7FFF, SETTLE_CYCLES=4, start pulse -> vectors 0..15 in order, o_done at cycle 81 after accept, o_pass=1, o_err_cnt=0, o_first_err_valid=0.
REQ-033 Gate output stuck at 1, i_truth=16'h7FFF -> o_err_cnt=1, o_first_err_vec=15, o_first_err_valid=1, o_pass=0.
REQ-034 AND4 gate in place of NAND4, i_truth=16'h7FFF -> o_err_cnt=16 with no wrap, o_first_err_vec=0, o_pass=0.
REQ-035 i_abort pulsed during SETTLE of vector 7 -> IDLE at next edge, o_a..o_d=0, no o_done, o_pass=0; a following start runs a full clean sweep.
REQ-036 i_rst_n pulsed low for less than one clock period mid-sweep, off clock edges -> all outputs 0 immediately, IDLE after release, no o_done.
REQ-037 i_start held high for the entire run -> no restart while busy; a second sweep begins the cycle after DONE.
